phys_reg_freelist: RTL and testbench
====================================

# phys_reg_freelist

R10K physical-register free list that shares the physical register file among the `N` dispatch slots each cycle. It presents up to `N` one-hot grants, pre-selected from the current free bitmap, to `stage_dispatch`. It consumes the grants dispatch accepts and returns registers freed by ROB retirement. On branch misprediction it rebuilds its state from the architectural map. The block holds the free bitmap and a registered free count that feed dispatch's structural-hazard check.

## Interface
- `N`, default `` `N `` — dispatch/retire width.
- `PHYS_REG_SZ`, default `` `PHYS_REG_SZ_R10K `` — number of physical registers.
- `ARCH_REG_SZ`, default `` `ARCH_REG_SZ `` — number of architectural registers; must be less than `PHYS_REG_SZ`.
- `clock`, in, 1 — single clock; all state updates on the rising edge.
- `reset`, in, 1 — synchronous, active-high.
- `alloc_req`, in, `[N-1:0]` — dispatch `free_alloc_valid`; bit i consumes `granted_regs[i]` this cycle.
- `granted_regs`, out, `[N-1:0][PHYS_REG_SZ-1:0]` — one-hot grant per slot; all-zero if no register is available for that slot.
- `free_slots`, out, `$clog2(PHYS_REG_SZ+1)` — registered count of free registers.
- `retire_valid`, in, `[N-1:0]` — retiring ROB entries that free a register.
- `retire_told`, in, `[N-1:0]` PHYS_TAG — Told of each retiring entry.
- `recover`, in, 1 — mispredict squash.
- `recover_free_mask`, in, `[PHYS_REG_SZ-1:0]` — 1 = register not referenced by the post-retire architectural map.
- `double_free`, out, 1 — sticky error flag; cleared only by reset.

## Operation
- **State.**
  - `free_map[PHYS_REG_SZ-1:0]`: 1 = free.
  - `free_cnt`, which always equals `popcount(free_map)`.
- **Grant selection (combinational, from registered `free_map` only).**
  - `granted_regs[i]` is the (i+1)-th lowest-index set bit of `free_map`.
  - If fewer than i+1 bits are set, `granted_regs[i]` is all-zero.
  - Grants are presented every cycle regardless of `alloc_req`, so dispatch can rename before deciding which slots to consume.
  - Grants are pairwise disjoint.
- **Allocation.**
  - `alloc_req[i]` clears the bit named by `granted_regs[i]`.
  - `alloc_req` need not be contiguous. A slot whose request is low leaves its granted register free; it is not re-offered to a later slot in the same cycle.
  - `alloc_req[i]` with an all-zero grant is ignored. Dispatch prevents this via `free_slots`.
- **Free.**
  - `retire_valid[i]` sets `free_map[retire_told[i]]`.
  - Tag 0 is the hardwired zero register: it is never granted, and freeing it is ignored.
  - Freeing a register that is already free (in the registered `free_map`) sets `double_free`; the bit stays set.
  - Duplicate tags within one retire group behave the same way: the register is set once and `double_free` is asserted.
- **Next state, normal cycle.** `free_map_next = (free_map & ~consumed) | freed`.
- **Next state, `recover` cycle.** `free_map_next = recover_free_mask | freed`; that cycle's `alloc_req` is ignored. `recover_free_mask[0]` is forced to 0.
- **Reset.**
  - Physical registers 0 to `ARCH_REG_SZ-1` are busy (identity map); registers `ARCH_REG_SZ` to `PHYS_REG_SZ-1` are free.
  - `free_cnt = PHYS_REG_SZ - ARCH_REG_SZ`.
  - `double_free = 0`.
  - `reset` has priority over `recover`, allocation and free.
- **Arithmetic.** `free_cnt` is recomputed as the popcount of `free_map_next`, not as a running increment/decrement, so it cannot drift after recovery. The maximum value `PHYS_REG_SZ-1` fits in the `free_slots` width.

## Timing
- `granted_regs` reflects the register state of the previous edge; it has zero-cycle visibility to dispatch.
- `free_slots` is registered and equals `free_cnt`.
- A register freed in cycle t is grantable in cycle t+1, never in cycle t.
- A register allocated in cycle t disappears from the grants in cycle t+1.
- Allocation and free of different registers in the same cycle both take effect.
- A same-cycle free of a register that is currently granted and consumed can only arise from a double free. It is flagged, and the result is free, since `freed` is applied last.
- Recovery latency is 1 cycle: grants in the cycle after `recover` come from the mask.
- `double_free` asserts in the cycle after the offending retire.
- Empty list: all grants are zero and `free_slots = 0`.
- Full list: `free_slots = PHYS_REG_SZ-1`. Only the zero register is excluded.

## Test plan
- **Reset, `N=3`, `PHYS=64`, `ARCH=32`.** Required: `free_slots = 32`; grants are one-hot at bits 32, 33 and 34; `double_free = 0`.
- **`alloc_req = 3'b101` with grants 32, 33, 34.** Required next cycle: grants 33, 35, 36; `free_slots = 30`.
- **Drain to empty, then retire Told 5 in cycle t.** Required: all grants are zero with `free_slots = 0` in cycle t. In cycle t+1, `granted_regs[0]` is bit 5 and `free_slots = 1`.
- **Simultaneous events.** Allocate 32 while retiring Told 7. Required next cycle: bit 32 busy, bit 7 free, `free_slots` unchanged.
- **Recovery.** Assert `recover` with a mask whose bits 40–63 are set, together with `alloc_req = 3'b111`. Required next cycle: `free_slots = 24`, grants at 40, 41, 42; the allocation is ignored.
- **Error and reset priority.** Retire Told 50 while register 50 is already free. Required: `double_free = 1` next cycle, and it stays set. A later `reset` clears it and restores `free_slots = 32`. Retiring Told 0 changes nothing.

Source files
------------

// File: rtl/phys_reg_freelist.sv
// Purpose: R10K physical-register free list; offers up to N one-hot grants per cycle, reclaims retired Told tags, rebuilds from the arch map on recover.
// Latency: grants are combinational from the registered free map; allocations, frees and recovery are visible one cycle later; free_slots is registered.
// Backpressure: none; dispatch throttles itself with free_slots, and a request against an all-zero grant is ignored.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   alloc_req[N]          - slot i consumes granted_regs[i] this cycle
//   granted_regs[N][PHYS] - one-hot grant per slot, all-zero when none is available
//   free_slots            - registered popcount of the free map
//   retire_valid/told[N]  - retiring ROB entries returning their Told register
//   recover, recover_free_mask - mispredict squash; mask bit = 1 means free in the arch map
//   double_free           - sticky error flag, cleared only by reset

`ifndef N
`define N 3
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif
`ifndef ARCH_REG_SZ
`define ARCH_REG_SZ 32
`endif

module phys_reg_freelist #(
   parameter int N           = `N,
   parameter int PHYS_REG_SZ = `PHYS_REG_SZ_R10K,
   parameter int ARCH_REG_SZ = `ARCH_REG_SZ,
   localparam int TAG_W      = $clog2(PHYS_REG_SZ),
   localparam int CNT_W      = $clog2(PHYS_REG_SZ + 1)
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic [N-1:0]                        alloc_req,
   output logic [N-1:0][PHYS_REG_SZ-1:0]       granted_regs,
   output logic [CNT_W-1:0]                    free_slots,
   input  logic [N-1:0]                        retire_valid,
   input  logic [N-1:0][TAG_W-1:0]             retire_told,
   input  logic                                recover,
   input  logic [PHYS_REG_SZ-1:0]              recover_free_mask,
   output logic                                double_free
);

   logic [PHYS_REG_SZ-1:0] free_map_q, free_map_d;
   logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;
   logic                   double_free_q, double_free_d;

   logic [PHYS_REG_SZ-1:0] consumed;
   logic [PHYS_REG_SZ-1:0] freed;
   logic [PHYS_REG_SZ-1:0] base_map;
   logic                   dbl_hit;
   int                     seen;

   // Slot i takes the (i+1)-th lowest set bit. Bit 0 is the hardwired zero
   // register and is skipped even if it were ever marked free.
   always_comb begin
      granted_regs = '0;
      seen         = 0;
      for (int b = 1; b < PHYS_REG_SZ; b++) begin
         if (free_map_q[b]) begin
            for (int i = 0; i < N; i++) begin
               if (seen == i) granted_regs[i][b] = 1'b1;
            end
            seen = seen + 1;
         end
      end
   end

   always_comb begin
      consumed = '0;
      if (!recover) begin
         for (int i = 0; i < N; i++) begin
            if (alloc_req[i]) consumed = consumed | granted_regs[i];
         end
      end

      // A tag is a double free if it is already free in the registered map or
      // was already returned by an earlier lane of this same retire group.
      freed   = '0;
      dbl_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (retire_valid[i] && (retire_told[i] != '0) && (int'(retire_told[i]) < PHYS_REG_SZ)) begin
            if (free_map_q[retire_told[i]] || freed[retire_told[i]]) dbl_hit = 1'b1;
            freed[retire_told[i]] = 1'b1;
         end
      end

      if (recover) base_map = {recover_free_mask[PHYS_REG_SZ-1:1], 1'b0};
      else         base_map = free_map_q & ~consumed;

      // Frees are applied last so a returned register always ends up free.
      free_map_d = base_map | freed;

      // Recount from scratch so the count cannot drift across recoveries.
      free_cnt_d = '0;
      for (int b = 0; b < PHYS_REG_SZ; b++) begin
         free_cnt_d = free_cnt_d + CNT_W'(free_map_d[b]);
      end

      double_free_d = double_free_q | dbl_hit;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         free_map_q    <= {{(PHYS_REG_SZ-ARCH_REG_SZ){1'b1}}, {ARCH_REG_SZ{1'b0}}};
         free_cnt_q    <= CNT_W'(PHYS_REG_SZ - ARCH_REG_SZ);
         double_free_q <= 1'b0;
      end else begin
         free_map_q    <= free_map_d;
         free_cnt_q    <= free_cnt_d;
         double_free_q <= double_free_d;
      end
   end

   assign free_slots  = free_cnt_q;
   assign double_free = double_free_q;

endmodule

// File: tb/tb_phys_reg_freelist.sv
module tb_phys_reg_freelist;
   localparam int N  = 3;
   localparam int P  = 64;
   localparam int A  = 32;
   localparam int TW = 6;
   localparam int CW = 7;

   typedef logic [N-1:0][P-1:0] grants_t;
   typedef logic [N-1:0][TW-1:0] tags_t;
   typedef struct {
      logic [P-1:0] map;
      logic         dbl;
   } exp_t;

   logic                clock = 1'b0;
   logic                reset;
   logic [N-1:0]        alloc_req;
   grants_t             granted_regs;
   logic [CW-1:0]       free_slots;
   logic [N-1:0]        retire_valid;
   tags_t               retire_told;
   logic                recover;
   logic [P-1:0]        recover_free_mask;
   logic                double_free;

   int total = 0;
   int bad   = 0;

   exp_t         sb[$];
   exp_t         ex;
   logic [P-1:0] m_map;
   logic         m_dbl;

   phys_reg_freelist #(.N(N), .PHYS_REG_SZ(P), .ARCH_REG_SZ(A)) dut (
      .clock             (clock),
      .reset             (reset),
      .alloc_req         (alloc_req),
      .granted_regs      (granted_regs),
      .free_slots        (free_slots),
      .retire_valid      (retire_valid),
      .retire_told       (retire_told),
      .recover           (recover),
      .recover_free_mask (recover_free_mask),
      .double_free       (double_free)
   );

   always #5 clock = ~clock;

   function automatic logic [P-1:0] bit_at(input int idx);
      logic [P-1:0] one;
      one = '0;
      one[idx] = 1'b1;
      return one;
   endfunction

   // Reference grant picker: walk slots, each searching upward from the
   // previous slot's pick; register 0 is never offered.
   function automatic grants_t model_grants(input logic [P-1:0] map);
      grants_t g;
      int      start;
      logic    found;
      g = '0;
      start = 1;
      for (int i = 0; i < N; i++) begin
         found = 1'b0;
         for (int b = 1; b < P; b++) begin
            if (!found && b >= start && map[b]) begin
               g[i][b] = 1'b1;
               start = b + 1;
               found = 1'b1;
            end
         end
      end
      return g;
   endfunction

   // Drive one cycle of stimulus, advance the model, push the expected
   // post-edge state, then step past the edge and return inputs to idle.
   task automatic cycle(input logic rst, input logic [N-1:0] areq, input logic [N-1:0] rv,
                        input tags_t rt, input logic rec, input logic [P-1:0] mask);
      grants_t      g;
      logic [P-1:0] freed;
      logic [P-1:0] nxt;
      exp_t         e;
      reset = rst; alloc_req = areq; retire_valid = rv; retire_told = rt;
      recover = rec; recover_free_mask = mask;
      if (rst) begin
         m_map = {{(P-A){1'b1}}, {A{1'b0}}};
         m_dbl = 1'b0;
      end else begin
         g = model_grants(m_map);
         freed = '0;
         for (int i = 0; i < N; i++) begin
            if (rv[i] && rt[i] != 0) begin
               if (m_map[rt[i]] || freed[rt[i]]) m_dbl = 1'b1;
               freed[rt[i]] = 1'b1;
            end
         end
         if (rec) nxt = mask & ~bit_at(0);
         else begin
            nxt = m_map;
            for (int i = 0; i < N; i++) if (areq[i]) nxt = nxt & ~g[i];
         end
         m_map = nxt | freed;
      end
      e.map = m_map;
      e.dbl = m_dbl;
      sb.push_back(e);
      @(posedge clock);
      #1;
      reset = 1'b0; alloc_req = '0; retire_valid = '0; retire_told = '0;
      recover = 1'b0; recover_free_mask = '0;
   endtask

   task automatic idle();
      cycle(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset();
      cycle(1'b1, '0, '0, '0, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd32) begin bad++; $display("FAIL reset_free_slots got=%0d want=32", free_slots); end
      total++;
      if (granted_regs[0] !== bit_at(32) || granted_regs[1] !== bit_at(33) || granted_regs[2] !== bit_at(34)) begin
         bad++; $display("FAIL reset_grants got=%h want=bits 32,33,34", granted_regs);
      end
      total++;
      if (double_free !== ex.dbl || double_free !== 1'b0) begin bad++; $display("FAIL reset_double_free got=%b want=0", double_free); end
   endtask

   task automatic test_alloc();
      cycle(1'b0, 3'b101, '0, '0, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (granted_regs[0] !== bit_at(33) || granted_regs[1] !== bit_at(35) || granted_regs[2] !== bit_at(36)) begin
         bad++; $display("FAIL alloc_101_grants got=%h want=bits 33,35,36", granted_regs);
      end
      total++;
      if (free_slots !== 7'd30) begin bad++; $display("FAIL alloc_101_free_slots got=%0d want=30", free_slots); end
      total++;
      if (granted_regs !== model_grants(ex.map)) begin bad++; $display("FAIL alloc_101_model got=%h want=%h", granted_regs, model_grants(ex.map)); end
   endtask

   task automatic test_simultaneous();
      tags_t rt;
      cycle(1'b1, '0, '0, '0, 1'b0, '0);
      ex = sb.pop_front();
      rt = '0; rt[0] = 6'd7;
      cycle(1'b0, 3'b001, 3'b001, rt, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (granted_regs[0] !== bit_at(7) || granted_regs[1] !== bit_at(33) || granted_regs[2] !== bit_at(34)) begin
         bad++; $display("FAIL simul_grants got=%h want=bits 7,33,34", granted_regs);
      end
      total++;
      if (free_slots !== 7'd32) begin bad++; $display("FAIL simul_free_slots got=%0d want=32", free_slots); end
   endtask

   task automatic test_drain_and_free();
      tags_t rt;
      int    guard;
      guard = 0;
      while (m_map != '0 && guard < 40) begin
         cycle(1'b0, 3'b111, '0, '0, 1'b0, '0);
         ex = sb.pop_front();
         total++;
         if (free_slots !== CW'($countones(ex.map)) || granted_regs !== model_grants(ex.map)) begin
            bad++; $display("FAIL drain_step got_cnt=%0d want_cnt=%0d got_g=%h want_g=%h",
                            free_slots, $countones(ex.map), granted_regs, model_grants(ex.map));
         end
         guard++;
      end
      total++;
      if (guard >= 40) begin bad++; $display("FAIL drain_bound got=%0d cycles want=<40", guard); end
      // Cycle t: list empty, retire Told 5 is being driven.
      rt = '0; rt[0] = 6'd5;
      reset = 1'b0; retire_valid = 3'b001; retire_told = rt;
      #1;
      total++;
      if (granted_regs !== '0 || free_slots !== 7'd0) begin
         bad++; $display("FAIL empty_state got_g=%h got_cnt=%0d want=0,0", granted_regs, free_slots);
      end
      cycle(1'b0, '0, 3'b001, rt, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (granted_regs[0] !== bit_at(5) || granted_regs[1] !== '0 || free_slots !== 7'd1) begin
         bad++; $display("FAIL free_after_empty got_g0=%h got_cnt=%0d want=bit5,1", granted_regs[0], free_slots);
      end
   endtask

   task automatic test_recover();
      logic [P-1:0] mask;
      mask = {{24{1'b1}}, {40{1'b0}}} | bit_at(0);
      cycle(1'b0, 3'b111, '0, '0, 1'b1, mask);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd24) begin bad++; $display("FAIL recover_free_slots got=%0d want=24", free_slots); end
      total++;
      if (granted_regs[0] !== bit_at(40) || granted_regs[1] !== bit_at(41) || granted_regs[2] !== bit_at(42)) begin
         bad++; $display("FAIL recover_grants got=%h want=bits 40,41,42", granted_regs);
      end
      mask = '1;
      cycle(1'b0, '0, '0, '0, 1'b1, mask);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd63 || granted_regs[0] !== bit_at(1)) begin
         bad++; $display("FAIL recover_full got_cnt=%0d got_g0=%h want=63,bit1", free_slots, granted_regs[0]);
      end
      mask = {{24{1'b1}}, {40{1'b0}}};
      cycle(1'b0, '0, '0, '0, 1'b1, mask);
      ex = sb.pop_front();
      total++;
      if (free_slots !== CW'($countones(ex.map))) begin bad++; $display("FAIL recover_restore got=%0d want=%0d", free_slots, $countones(ex.map)); end
   endtask

   task automatic test_double_free_and_reset();
      tags_t rt;
      rt = '0; rt[0] = 6'd50;
      cycle(1'b0, '0, 3'b001, rt, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (double_free !== 1'b1 || free_slots !== 7'd24) begin
         bad++; $display("FAIL dbl_free_flag got_dbl=%b got_cnt=%0d want=1,24", double_free, free_slots);
      end
      idle();
      ex = sb.pop_front();
      total++;
      if (double_free !== ex.dbl || double_free !== 1'b1) begin bad++; $display("FAIL dbl_free_sticky got=%b want=1", double_free); end
      // Duplicate busy tag within one group: set once.
      rt = '0; rt[0] = 6'd10; rt[2] = 6'd10;
      cycle(1'b0, '0, 3'b101, rt, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd25 || granted_regs[0] !== bit_at(10)) begin
         bad++; $display("FAIL dup_group got_cnt=%0d got_g0=%h want=25,bit10", free_slots, granted_regs[0]);
      end
      // Reset wins over recover, allocation and free in the same cycle.
      rt = '0; rt[1] = 6'd3;
      cycle(1'b1, 3'b111, 3'b010, rt, 1'b1, '1);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd32 || double_free !== 1'b0 || granted_regs[0] !== bit_at(32)) begin
         bad++; $display("FAIL reset_priority got_cnt=%0d got_dbl=%b got_g0=%h want=32,0,bit32", free_slots, double_free, granted_regs[0]);
      end
      // Told 0 is the zero register: nothing changes.
      rt = '0; rt[0] = 6'd0;
      cycle(1'b0, '0, 3'b001, rt, 1'b0, '0);
      ex = sb.pop_front();
      total++;
      if (free_slots !== 7'd32 || double_free !== 1'b0 || granted_regs !== model_grants(ex.map)) begin
         bad++; $display("FAIL zero_reg_free got_cnt=%0d got_dbl=%b want=32,0", free_slots, double_free);
      end
   endtask

   task automatic test_back_to_back();
      tags_t rt;
      for (int k = 0; k < 6; k++) begin
         rt = '0;
         rt[0] = TW'($urandom_range(1, P-1));
         rt[1] = TW'($urandom_range(1, P-1));
         cycle(1'b0, N'($urandom_range(0, 7)), N'($urandom_range(0, 3)), rt, 1'b0, '0);
         ex = sb.pop_front();
         total++;
         if (free_slots !== CW'($countones(ex.map)) || granted_regs !== model_grants(ex.map) || double_free !== ex.dbl) begin
            bad++; $display("FAIL b2b_%0d got_cnt=%0d want_cnt=%0d got_dbl=%b want_dbl=%b",
                            k, free_slots, $countones(ex.map), double_free, ex.dbl);
         end
      end
   endtask

   initial begin
      reset = 1'b1; alloc_req = '0; retire_valid = '0; retire_told = '0;
      recover = 1'b0; recover_free_mask = '0;
      m_map = '0; m_dbl = 1'b0;
      #1;
      test_reset();
      test_alloc();
      test_simultaneous();
      test_drain_and_free();
      test_recover();
      test_double_free_and_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
